// File: rtl/regfile_sb.sv
// Multi-port register file with hardwired-zero R0, optional write forwarding,
// and a per-register busy scoreboard for multi-cycle producers.
module regfile_sb #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NREAD  = 2,
   parameter int BYPASS = 1
) (
   input  logic                      Clk,
   input  logic                      Rst,
   input  logic [NREAD*ADDR_W-1:0]   ReadReg,
   output logic [NREAD*DATA_W-1:0]   ReadData,
   output logic [NREAD-1:0]          ReadBusy,
   input  logic [ADDR_W-1:0]         WriteReg,
   input  logic [DATA_W-1:0]         WriteData,
   input  logic                      RegWrite,
   input  logic [ADDR_W-1:0]         ResvReg,
   input  logic                      ResvValid,
   output logic [(1<<ADDR_W)-1:0]    BusyVec
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DEPTH-1:0]  r_busy;

   logic w_wr;
   logic w_rv;

   assign w_wr = RegWrite && (WriteReg != '0);
   assign w_rv = ResvValid && (ResvReg != '0);

   // A reservation on the same edge as a write wins the busy bit
   always_ff @(posedge Clk) begin
      if (Rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_busy <= '0;
      end else begin
         if (w_wr) begin
            r_mem[WriteReg]  <= WriteData;
            r_busy[WriteReg] <= 1'b0;
         end
         if (w_rv) begin
            r_busy[ResvReg] <= 1'b1;
         end
      end
   end

   assign BusyVec = r_busy;

   for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
      logic [ADDR_W-1:0] w_addr;
      logic              w_fwd;
      logic              w_resv_hit;

      assign w_addr     = ReadReg[gi*ADDR_W +: ADDR_W];
      assign w_fwd      = (BYPASS != 0) && w_wr && (WriteReg == w_addr);
      assign w_resv_hit = w_rv && (ResvReg == w_addr);

      assign ReadData[gi*DATA_W +: DATA_W] =
         (w_addr == '0) ? '0 :
         w_fwd          ? WriteData :
                          r_mem[w_addr];

      assign ReadBusy[gi] =
         (w_fwd && !w_resv_hit) ? 1'b0 : r_busy[w_addr];
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed checks for regfile_sb: default build, a no-bypass build
// and a four-read-port build sharing the write/reserve stimulus.
module tb_regfile_sb;

   logic         clk;
   logic         rst;
   logic [9:0]   rreg;
   logic [63:0]  rdata;
   logic [1:0]   rbusy;
   logic [63:0]  rdata_nb;
   logic [1:0]   rbusy_nb;
   logic [31:0]  busy_nb;
   logic [19:0]  rreg4;
   logic [127:0] rdata4;
   logic [3:0]   rbusy4;
   logic [31:0]  busy4;
   logic [4:0]   wreg;
   logic [31:0]  wdata;
   logic         we;
   logic [4:0]   resreg;
   logic         resv;
   logic [31:0]  busyvec;

   int n_tests;
   int n_fail;

   regfile_sb dut (
      .Clk(clk), .Rst(rst), .ReadReg(rreg), .ReadData(rdata),
      .ReadBusy(rbusy), .WriteReg(wreg), .WriteData(wdata),
      .RegWrite(we), .ResvReg(resreg), .ResvValid(resv),
      .BusyVec(busyvec)
   );

   regfile_sb #(.BYPASS(0)) dut_nb (
      .Clk(clk), .Rst(rst), .ReadReg(rreg), .ReadData(rdata_nb),
      .ReadBusy(rbusy_nb), .WriteReg(wreg), .WriteData(wdata),
      .RegWrite(we), .ResvReg(resreg), .ResvValid(resv),
      .BusyVec(busy_nb)
   );

   regfile_sb #(.NREAD(4)) dut4 (
      .Clk(clk), .Rst(rst), .ReadReg(rreg4), .ReadData(rdata4),
      .ReadBusy(rbusy4), .WriteReg(wreg), .WriteData(wdata),
      .RegWrite(we), .ResvReg(resreg), .ResvValid(resv),
      .BusyVec(busy4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we     = 1'b0;
      resv   = 1'b0;
      wreg   = '0;
      wdata  = '0;
      resreg = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      we = 1'b1; wreg = 5'd5; wdata = 32'h1111_2222;
      resv = 1'b1; resreg = 5'd3;
      rreg = {5'd3, 5'd5};
      tick();
      tick();
      idle();
      #1;
      n_tests++;
      if (rdata !== 64'h0) begin
         n_fail++;
         $display("FAIL reset_rdata got %h want 0", rdata);
      end
      n_tests++;
      if (rbusy !== 2'b00 || busyvec !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_busy got %b/%h want 0/0", rbusy, busyvec);
      end
      // bypass is combinational even under reset, but nothing commits
      we = 1'b1; wreg = 5'd6; wdata = 32'hCAFE_0006;
      rreg = {5'd6, 5'd6};
      #1;
      n_tests++;
      if (rdata !== {32'hCAFE_0006, 32'hCAFE_0006}) begin
         n_fail++;
         $display("FAIL rst_bypass got %h want cafe0006x2", rdata);
      end
      tick();
      idle();
      #1;
      n_tests++;
      if (rdata !== 64'h0) begin
         n_fail++;
         $display("FAIL rst_nocommit got %h want 0", rdata);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_write_read();
      we = 1'b1; wreg = 5'd5; wdata = 32'h0000_00A5;
      tick();
      idle();
      rreg = {5'd5, 5'd5};
      #1;
      n_tests++;
      if (rdata !== {32'hA5, 32'hA5}) begin
         n_fail++;
         $display("FAIL wr_rd got %h want a5x2", rdata);
      end
      n_tests++;
      if (rbusy !== 2'b00) begin
         n_fail++;
         $display("FAIL wr_rd_busy got %b want 00", rbusy);
      end
   endtask

   task automatic test_r0();
      we = 1'b1; wreg = 5'd0; wdata = 32'hFFFF_FFFF;
      rreg = {5'd0, 5'd0};
      #1;
      n_tests++;
      if (rdata !== 64'h0 || rdata_nb !== 64'h0) begin
         n_fail++;
         $display("FAIL r0_same got %h/%h want 0", rdata, rdata_nb);
      end
      tick();
      idle();
      #1;
      n_tests++;
      if (rdata !== 64'h0) begin
         n_fail++;
         $display("FAIL r0_next got %h want 0", rdata);
      end
      resv = 1'b1; resreg = 5'd0;
      tick();
      idle();
      #1;
      n_tests++;
      if (busyvec !== 32'h0 || rbusy !== 2'b00) begin
         n_fail++;
         $display("FAIL r0_resv got %h/%b want 0/00", busyvec, rbusy);
      end
   endtask

   task automatic test_bypass();
      we = 1'b1; wreg = 5'd7; wdata = 32'd3;
      tick();
      wdata = 32'hFFFF_FFFE;
      rreg  = {5'd7, 5'd7};
      #1;
      n_tests++;
      if (rdata !== {32'hFFFF_FFFE, 32'hFFFF_FFFE}) begin
         n_fail++;
         $display("FAIL bypass got %h want fffffffex2", rdata);
      end
      n_tests++;
      if (rdata_nb !== {32'd3, 32'd3}) begin
         n_fail++;
         $display("FAIL nobypass got %h want 3x2", rdata_nb);
      end
      tick();
      idle();
      #1;
      n_tests++;
      if (rdata_nb !== {32'hFFFF_FFFE, 32'hFFFF_FFFE}) begin
         n_fail++;
         $display("FAIL nobypass_next got %h want fffffffex2", rdata_nb);
      end
   endtask

   task automatic test_reserve();
      resv = 1'b1; resreg = 5'd9;
      tick();
      idle();
      rreg = {5'd9, 5'd9};
      #1;
      n_tests++;
      if (rbusy !== 2'b11 || busyvec[9] !== 1'b1) begin
         n_fail++;
         $display("FAIL resv_busy got %b/%b want 11/1", rbusy, busyvec[9]);
      end
      tick();
      we = 1'b1; wreg = 5'd9; wdata = 32'h1234;
      #1;
      n_tests++;
      if (rbusy !== 2'b00 || rdata[31:0] !== 32'h1234) begin
         n_fail++;
         $display("FAIL resv_fwd got %b/%h want 00/1234", rbusy, rdata[31:0]);
      end
      n_tests++;
      if (rbusy_nb !== 2'b11) begin
         n_fail++;
         $display("FAIL resv_nofwd got %b want 11", rbusy_nb);
      end
      tick();
      idle();
      #1;
      n_tests++;
      if (busyvec[9] !== 1'b0 || rbusy !== 2'b00) begin
         n_fail++;
         $display("FAIL resv_clr got %b/%b want 0/00", busyvec[9], rbusy);
      end
   endtask

   task automatic test_same_edge();
      resv = 1'b1; resreg = 5'd12;
      we = 1'b1; wreg = 5'd12; wdata = 32'd77;
      rreg = {5'd12, 5'd12};
      tick();
      idle();
      #1;
      n_tests++;
      if (rdata !== {32'd77, 32'd77}) begin
         n_fail++;
         $display("FAIL same_data got %h want 77x2", rdata);
      end
      n_tests++;
      if (busyvec[12] !== 1'b1 || rbusy !== 2'b11) begin
         n_fail++;
         $display("FAIL same_busy got %b/%b want 1/11", busyvec[12], rbusy);
      end
      // forward hits but a same-cycle reservation keeps the flag
      resv = 1'b1; resreg = 5'd12;
      we = 1'b1; wreg = 5'd12; wdata = 32'd78;
      #1;
      n_tests++;
      if (rbusy !== 2'b11) begin
         n_fail++;
         $display("FAIL same_fwd_busy got %b want 11", rbusy);
      end
      tick();
      idle();
   endtask

   task automatic test_reset_mid();
      resv = 1'b1; resreg = 5'd3;
      tick();
      idle();
      we = 1'b1; wreg = 5'd4; wdata = 32'd9;
      tick();
      idle();
      rreg = {5'd3, 5'd4};
      #1;
      n_tests++;
      if (busyvec[3] !== 1'b1 || rdata[31:0] !== 32'd9) begin
         n_fail++;
         $display("FAIL mid_pre got %b/%h want 1/9", busyvec[3], rdata[31:0]);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      n_tests++;
      if (busyvec !== 32'h0 || rdata !== 64'h0) begin
         n_fail++;
         $display("FAIL mid_rst got %h/%h want 0/0", busyvec, rdata);
      end
      we = 1'b1; wreg = 5'd3; wdata = 32'd5;
      tick();
      idle();
      #1;
      n_tests++;
      if (busyvec !== 32'h0 || rdata[63:32] !== 32'd5) begin
         n_fail++;
         $display("FAIL mid_wr got %h/%h want 0/5", busyvec, rdata[63:32]);
      end
   endtask

   task automatic test_nread4();
      we = 1'b1;
      wreg = 5'd1; wdata = 32'd11; tick();
      wreg = 5'd2; wdata = 32'd22; tick();
      wreg = 5'd3; wdata = 32'd33; tick();
      wreg = 5'd4; wdata = 32'd44; tick();
      idle();
      rreg4 = {5'd4, 5'd3, 5'd2, 5'd1};
      #1;
      n_tests++;
      if (rdata4 !== {32'd44, 32'd33, 32'd22, 32'd11}) begin
         n_fail++;
         $display("FAIL n4_distinct got %h want 44/33/22/11", rdata4);
      end
      n_tests++;
      if (rbusy4 !== 4'b0000) begin
         n_fail++;
         $display("FAIL n4_busy got %b want 0000", rbusy4);
      end
      rreg4 = {5'd2, 5'd2, 5'd2, 5'd2};
      #1;
      n_tests++;
      if (rdata4 !== {4{32'd22}}) begin
         n_fail++;
         $display("FAIL n4_same got %h want 22x4", rdata4);
      end
      rreg4 = {5'd0, 5'd31, 5'd4, 5'd1};
      #1;
      n_tests++;
      if (rdata4 !== {32'd0, 32'd0, 32'd44, 32'd11}) begin
         n_fail++;
         $display("FAIL n4_mix got %h want 0/0/44/11", rdata4);
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst     = 1'b1;
      rreg    = '0;
      rreg4   = '0;
      idle();
      test_reset();
      test_write_read();
      test_r0();
      test_bypass();
      test_reserve();
      test_same_edge();
      test_reset_mid();
      test_nread4();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning register address width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter NREAD, default 2, meaning number of independent read ports (1..4).
REQ-004 SHALL have parameter BYPASS, default 1, meaning 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-005 SHALL have port Clk  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port Rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port ReadReg  input  NREAD*ADDR_W  packed read addresses; port i at bits [i*ADDR_W +: ADDR_W].
REQ-008 SHALL have port ReadData  output  NREAD*DATA_W  packed signed read data; port i at bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have port ReadBusy  output  NREAD  per-port flag: addressed register awaits a reserved write.
REQ-010 SHALL have port WriteReg  input  ADDR_W  write address.
REQ-011 SHALL have port WriteData  input  DATA_W  signed write data.
REQ-012 SHALL have port RegWrite  input  1  write enable.
REQ-013 SHALL have port ResvReg  input  ADDR_W  register to reserve (multi-cycle producer issued).
REQ-014 SHALL have port ResvValid  input  1  reservation request strobe.
REQ-015 SHALL have port BusyVec  output  2**ADDR_W  registered busy bit per register, for debug.

Function
REQ-016 SHALL treat register 0 as hardwired zero: reads return 0, writes ignored, never busy.
REQ-017 SHALL perform reads combinationally: ReadData[i] = mem[ReadReg[i]], zero-latency.
REQ-018 SHALL commit a write on the rising edge when RegWrite=1 and WriteReg!=0; visible on unbypassed reads the next cycle.
REQ-019 SHALL, when BYPASS=1, RegWrite=1, WriteReg!=0 and WriteReg==ReadReg[i], drive ReadData[i]=WriteData in the same cycle.
REQ-020 SHALL, when BYPASS=0, return the pre-write value on a same-cycle read of the register being written.
REQ-021 SHALL keep one busy bit per register; ResvValid=1 with ResvReg!=0 sets busy[ResvReg] at the next edge.
REQ-022 SHALL clear busy[WriteReg] at the edge where RegWrite=1 commits.
REQ-023 SHALL, on the same edge with ResvValid and RegWrite targeting the same register, leave busy set (new reservation wins) and commit the data.
REQ-024 SHALL allow reserve of an already-busy register (no-op on bit) and write to a non-busy register (data committed, bit stays 0).
REQ-025 SHALL drive ReadBusy[i] = busy[ReadReg[i]], except 0 when a BYPASS=1 forward hits port i and no same-cycle reservation targets that register.
REQ-026 SHALL serve all NREAD ports independently, including identical addresses on several ports.
REQ-027 SHALL drive BusyVec directly from the busy register; bit 0 constant 0.

Reset
REQ-028 SHALL, on Rst=1 at a rising edge, clear all registers to 0 and all busy bits to 0, dominating RegWrite and ResvValid that cycle.
REQ-029 SHALL, with Rst held, show ReadData=0, ReadBusy=0, BusyVec=0 from the first edge onward; combinational bypass still applies while Rst=1 but no write commits.
REQ-030 SHALL abandon any outstanding reservation on reset mid-operation; a later write to that register behaves as an unreserved write.

Verification
REQ-031 Reset then write R5=0x0000_00A5, read R5 next cycle on port 0 and port 1 -> both 0x0000_00A5, ReadBusy=00.
REQ-032 RegWrite R0=0xFFFF_FFFF, read R0 same and next cycle -> 0 both cycles; BusyVec[0]=0 after ResvValid R0.
REQ-033 BYPASS=1: R7=3 stored, same cycle write R7=-2 and read R7 -> ReadData=0xFFFF_FFFE; BYPASS=0 same stimulus -> 3, then -2 next cycle.
REQ-034 ResvValid R9 -> next cycle ReadBusy=1 on R9; cycle later RegWrite R9=0x1234 (bypass) -> ReadBusy=0, ReadData=0x1234; BusyVec[9]=0 after edge.
REQ-035 Same edge ResvValid R12 and RegWrite R12=77 -> R12 reads 77, BusyVec[12]=1 after edge.
REQ-036 Reserve R3, write R4=9, assert Rst one cycle -> BusyVec=0, R4 reads 0; NREAD=4 run with all ports on distinct registers reads correct values.
